// File: rtl/wordlit_arbiter_if.sv
// Bundle of requester, datapath and response signals around wordlit_arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// environment (requesters, datapath result, response consumer).
interface wordlit_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic [7:0]  dp_in;
    logic        dp_issue;
    logic [15:0] dp_out;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    logic        busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, dp_out, rsp_ready,
        output req0_ready, req1_ready, dp_in, dp_issue, rsp_valid, rsp_data,
        output rsp_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, dp_out, rsp_ready,
        input  req0_ready, req1_ready, dp_in, dp_issue, rsp_valid, rsp_data,
        input  rsp_id, busy
    );
endinterface

// File: rtl/wordlit_arbiter.sv
// Two-requester round-robin front end for the shared word-literal datapath.
// Operands are issued one per cycle, tracked through the datapath latency by
// requester id, and results queue in an in-order response FIFO. Acceptance is
// limited by credit = free FIFO slots not already promised to in-flight ops.
module wordlit_arbiter #(
    parameter int DP_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    wordlit_arbiter_if.slave bus
);
    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = AW + 1;

    // control state
    logic                  last_grant_q, last_grant_d;
    logic [DP_LATENCY-1:0] trk_vld_q, trk_vld_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    // data state (never reset; qualified by the control state above)
    logic [DP_LATENCY-1:0] trk_id_q, trk_id_d;
    logic [15:0]           mem_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  id_mem_q;

    logic [2:0]  inflight;
    logic [4:0]  occupancy;
    logic        credit_ok;
    logic        both_valid;
    logic        grant;
    logic        grant_id;
    logic        push;
    logic        pop;
    logic        head_valid;

    // Credit from registered occupancy only, then round-robin grant.
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < DP_LATENCY; i++) begin
            inflight = inflight + {2'b00, trk_vld_q[i]};
        end
        occupancy  = 5'(count_q) + 5'(inflight);
        credit_ok  = occupancy < 5'(RSP_DEPTH);
        both_valid = bus.req0_valid & bus.req1_valid;
        // With a single requester its id is simply req1_valid; with both,
        // the one that did not win last time goes next.
        grant_id   = both_valid ? ~last_grant_q : bus.req1_valid;
        // No acceptance while reset is held: the operand would be lost.
        grant      = (bus.req0_valid | bus.req1_valid) & credit_ok & ~rst;
        last_grant_d = grant ? grant_id : last_grant_q;
    end

    assign bus.req0_ready = grant & ~grant_id;
    assign bus.req1_ready = grant & grant_id;
    assign bus.dp_issue   = grant;
    assign bus.dp_in      = grant ? (grant_id ? bus.req1_data : bus.req0_data) : 8'h00;

    // In-flight tracker: stage 0 takes the new issue, the last stage pushes.
    always_comb begin
        trk_vld_d    = trk_vld_q;
        trk_id_d     = trk_id_q;
        trk_vld_d[0] = grant;
        trk_id_d[0]  = grant_id;
        for (int i = 1; i < DP_LATENCY; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_id_d[i]  = trk_id_q[i-1];
        end
    end

    assign push       = trk_vld_q[DP_LATENCY-1];
    assign head_valid = (count_q != '0) & ~rst;
    assign pop        = head_valid & bus.rsp_ready;

    // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    assign bus.rsp_valid = head_valid;
    assign bus.rsp_data  = head_valid ? mem_q[rd_ptr_q]    : 16'h0000;
    assign bus.rsp_id    = head_valid ? id_mem_q[rd_ptr_q] : 1'b0;
    assign bus.busy      = ~rst & ((inflight != 3'd0) | (count_q != '0));

    // Control registers; reset also drops any result still in the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            trk_vld_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            trk_vld_q    <= trk_vld_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Result storage and tracker ids, written unconditionally by their enables.
    always_ff @(posedge clk) begin
        trk_id_q <= trk_id_d;
        if (push) begin
            mem_q[wr_ptr_q]    <= bus.dp_out;
            id_mem_q[wr_ptr_q] <= trk_id_q[DP_LATENCY-1];
        end
    end
endmodule
